// File: rtl/alu_issue_queue.sv
// alu_issue_queue
//   Reservation station in front of the single-cycle arithmetic unit. It holds
//   dispatched ALU-class instructions until both source operands are known. It
//   snoops the common data bus (CDB) to wake waiting operands, and issues the
//   oldest ready instruction, one per cycle.
//
// Ports
//   clk_i, reset_i          clock and synchronous active-high reset
//   flush_i                 drop every entry (mispredict recovery)
//   dispatch_*              dispatch handshake plus instruction and operand payload
//   cdb_valid_i/tag/value   result broadcast used for operand wakeup
//   issue_ready_i           downstream can take an issue this cycle
//   alu_request_o, issue_*  issued instruction with resolved operands and rd tag
module alu_issue_queue #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 6
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             flush_i,
  input  logic             dispatch_valid_i,
  output logic             dispatch_ready_o,
  input  logic [31:0]      dispatch_pc_i,
  input  logic [31:0]      dispatch_inst_i,
  input  logic [TAG_W-1:0] dispatch_rd_tag_i,
  input  logic             dispatch_rs1_ready_i,
  input  logic [TAG_W-1:0] dispatch_rs1_tag_i,
  input  logic [31:0]      dispatch_rs1_value_i,
  input  logic             dispatch_rs2_ready_i,
  input  logic [TAG_W-1:0] dispatch_rs2_tag_i,
  input  logic [31:0]      dispatch_rs2_value_i,
  input  logic             cdb_valid_i,
  input  logic [TAG_W-1:0] cdb_tag_i,
  input  logic [31:0]      cdb_value_i,
  input  logic             issue_ready_i,
  output logic             alu_request_o,
  output logic [31:0]      issue_pc_o,
  output logic [31:0]      issue_inst_o,
  output logic [31:0]      issue_rs1_value_o,
  output logic [31:0]      issue_rs2_value_o,
  output logic [TAG_W-1:0] issue_rd_tag_o
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic             valid;
    logic [31:0]      pc;
    logic [31:0]      inst;
    logic [TAG_W-1:0] rd_tag;
    logic             rs1_ready;
    logic [TAG_W-1:0] rs1_tag;
    logic [31:0]      rs1_value;
    logic             rs2_ready;
    logic [TAG_W-1:0] rs2_tag;
    logic [31:0]      rs2_value;
  } entry_t;

  // Compacting storage: slot 0 is always the oldest entry and valid slots are
  // contiguous from 0 up to count_q-1.
  entry_t           entries_q [DEPTH];
  entry_t           entries_d [DEPTH];
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  logic             cand_found;
  logic [IDX_W-1:0] sel_idx;
  logic             dispatch_accept;
  entry_t           new_entry;

  // Oldest-first select, using only registered state, so no dispatch or CDB
  // input can reach the issue outputs combinationally.
  always_comb begin
    cand_found = 1'b0;
    sel_idx    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!cand_found && entries_q[i].valid &&
          entries_q[i].rs1_ready && entries_q[i].rs2_ready) begin
        cand_found = 1'b1;
        sel_idx    = IDX_W'(i);
      end
    end
  end

  // Reset is gated in here so that a reset arriving mid-stream never lets an
  // entry issue in the same cycle that it is being dropped.
  assign alu_request_o     = cand_found & issue_ready_i & ~flush_i & ~reset_i;
  assign issue_pc_o        = cand_found ? entries_q[sel_idx].pc        : '0;
  assign issue_inst_o      = cand_found ? entries_q[sel_idx].inst      : '0;
  assign issue_rs1_value_o = cand_found ? entries_q[sel_idx].rs1_value : '0;
  assign issue_rs2_value_o = cand_found ? entries_q[sel_idx].rs2_value : '0;
  assign issue_rd_tag_o    = cand_found ? entries_q[sel_idx].rd_tag    : '0;

  // Readiness looks only at occupancy. A slot freed by a same-cycle issue
  // is not reused, which is why one bubble appears after the queue is full.
  assign dispatch_ready_o = (count_q < CNT_W'(DEPTH)) & ~flush_i;
  assign dispatch_accept  = dispatch_valid_i & dispatch_ready_o;

  // Build the incoming entry. A waiting source whose producer broadcasts in
  // this same cycle is captured now, otherwise it would miss the broadcast.
  always_comb begin
    new_entry           = '0;
    new_entry.valid     = 1'b1;
    new_entry.pc        = dispatch_pc_i;
    new_entry.inst      = dispatch_inst_i;
    new_entry.rd_tag    = dispatch_rd_tag_i;
    new_entry.rs1_ready = dispatch_rs1_ready_i;
    new_entry.rs1_tag   = dispatch_rs1_tag_i;
    new_entry.rs1_value = dispatch_rs1_value_i;
    new_entry.rs2_ready = dispatch_rs2_ready_i;
    new_entry.rs2_tag   = dispatch_rs2_tag_i;
    new_entry.rs2_value = dispatch_rs2_value_i;
    if (!dispatch_rs1_ready_i && cdb_valid_i && (dispatch_rs1_tag_i == cdb_tag_i)) begin
      new_entry.rs1_ready = 1'b1;
      new_entry.rs1_value = cdb_value_i;
    end
    if (!dispatch_rs2_ready_i && cdb_valid_i && (dispatch_rs2_tag_i == cdb_tag_i)) begin
      new_entry.rs2_ready = 1'b1;
      new_entry.rs2_value = cdb_value_i;
    end
  end

  // Next-state is built in three steps: remove the issued entry, wake operands
  // on the shifted image, then append the dispatch. Doing the wakeup after the
  // shift lets an entry both move down and capture the CDB value in one edge.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      entries_d[i] = entries_q[i];
    end
    count_d = count_q;

    if (alu_request_o) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        if (IDX_W'(i) >= sel_idx) begin
          entries_d[i] = entries_q[i + 1];
        end
      end
      entries_d[DEPTH - 1] = '0;
      count_d = count_q - CNT_W'(1);
    end

    if (cdb_valid_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (entries_d[i].valid && !entries_d[i].rs1_ready &&
            (entries_d[i].rs1_tag == cdb_tag_i)) begin
          entries_d[i].rs1_ready = 1'b1;
          entries_d[i].rs1_value = cdb_value_i;
        end
        if (entries_d[i].valid && !entries_d[i].rs2_ready &&
            (entries_d[i].rs2_tag == cdb_tag_i)) begin
          entries_d[i].rs2_ready = 1'b1;
          entries_d[i].rs2_value = cdb_value_i;
        end
      end
    end

    // count_d < DEPTH is guaranteed here because acceptance requires
    // count_q < DEPTH and the issue step can only lower it.
    if (dispatch_accept) begin
      entries_d[count_d[IDX_W-1:0]] = new_entry;
      count_d = count_d + CNT_W'(1);
    end

    if (flush_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries_d[i] = '0;
      end
      count_d = '0;
    end
  end

  // State register; reset overrides flush, dispatch and wakeup.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries_q[i] <= '0;
      end
      count_q <= '0;
    end else begin
      entries_q <= entries_d;
      count_q   <= count_d;
    end
  end

endmodule

// File: tb/tb_alu_issue_queue.sv
// tb_alu_issue_queue
//   Drives directed and random traffic into alu_issue_queue. A queue-based
//   reference model predicts every issue. A monitor process pops those
//   predictions and compares them against what the DUT presents.
module tb_alu_issue_queue;

  localparam int DEPTH = 4;
  localparam int TAG_W = 6;

  logic             clk_i = 1'b0;
  logic             reset_i = 1'b1;
  logic             flush_i = 1'b0;
  logic             dispatch_valid_i = 1'b0;
  logic             dispatch_ready_o;
  logic [31:0]      dispatch_pc_i = '0;
  logic [31:0]      dispatch_inst_i = '0;
  logic [TAG_W-1:0] dispatch_rd_tag_i = '0;
  logic             dispatch_rs1_ready_i = 1'b0;
  logic [TAG_W-1:0] dispatch_rs1_tag_i = '0;
  logic [31:0]      dispatch_rs1_value_i = '0;
  logic             dispatch_rs2_ready_i = 1'b0;
  logic [TAG_W-1:0] dispatch_rs2_tag_i = '0;
  logic [31:0]      dispatch_rs2_value_i = '0;
  logic             cdb_valid_i = 1'b0;
  logic [TAG_W-1:0] cdb_tag_i = '0;
  logic [31:0]      cdb_value_i = '0;
  logic             issue_ready_i = 1'b0;
  logic             alu_request_o;
  logic [31:0]      issue_pc_o;
  logic [31:0]      issue_inst_o;
  logic [31:0]      issue_rs1_value_o;
  logic [31:0]      issue_rs2_value_o;
  logic [TAG_W-1:0] issue_rd_tag_o;

  typedef struct {
    logic [31:0]      pc;
    logic [31:0]      inst;
    logic [TAG_W-1:0] rd;
    logic             r1;
    logic [TAG_W-1:0] t1;
    logic [31:0]      v1;
    logic             r2;
    logic [TAG_W-1:0] t2;
    logic [31:0]      v2;
  } m_entry_t;

  typedef struct {
    logic             reset;
    logic             flush;
    logic             dvalid;
    m_entry_t         d;
    logic             cdb_valid;
    logic [TAG_W-1:0] cdb_tag;
    logic [31:0]      cdb_value;
    logic             issue_ready;
  } stim_t;

  typedef struct {
    logic [31:0]      pc;
    logic [31:0]      inst;
    logic [31:0]      v1;
    logic [31:0]      v2;
    logic [TAG_W-1:0] rd;
  } exp_issue_t;

  m_entry_t   model_q[$];
  exp_issue_t exp_q[$];
  int         num_checks = 0;
  int         num_errors = 0;

  alu_issue_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk_i                (clk_i),
    .reset_i              (reset_i),
    .flush_i              (flush_i),
    .dispatch_valid_i     (dispatch_valid_i),
    .dispatch_ready_o     (dispatch_ready_o),
    .dispatch_pc_i        (dispatch_pc_i),
    .dispatch_inst_i      (dispatch_inst_i),
    .dispatch_rd_tag_i    (dispatch_rd_tag_i),
    .dispatch_rs1_ready_i (dispatch_rs1_ready_i),
    .dispatch_rs1_tag_i   (dispatch_rs1_tag_i),
    .dispatch_rs1_value_i (dispatch_rs1_value_i),
    .dispatch_rs2_ready_i (dispatch_rs2_ready_i),
    .dispatch_rs2_tag_i   (dispatch_rs2_tag_i),
    .dispatch_rs2_value_i (dispatch_rs2_value_i),
    .cdb_valid_i          (cdb_valid_i),
    .cdb_tag_i            (cdb_tag_i),
    .cdb_value_i          (cdb_value_i),
    .issue_ready_i        (issue_ready_i),
    .alu_request_o        (alu_request_o),
    .issue_pc_o           (issue_pc_o),
    .issue_inst_o         (issue_inst_o),
    .issue_rs1_value_o    (issue_rs1_value_o),
    .issue_rs2_value_o    (issue_rs2_value_o),
    .issue_rd_tag_o       (issue_rd_tag_o)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  always #5 clk_i = ~clk_i;

  // Safety net so the run can never hang.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    num_checks++;
    if (actual !== expected) begin
      num_errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic stim_t idleStim(input logic issue_ready);
    stim_t s;
    s.reset       = 1'b0;
    s.flush       = 1'b0;
    s.dvalid      = 1'b0;
    s.d           = '{default: '0};
    s.cdb_valid   = 1'b0;
    s.cdb_tag     = '0;
    s.cdb_value   = '0;
    s.issue_ready = issue_ready;
    return s;
  endfunction

  function automatic stim_t mkDispatch(input logic [31:0] pc, input logic [31:0] inst,
                                       input logic [TAG_W-1:0] rd,
                                       input logic r1, input logic [TAG_W-1:0] t1,
                                       input logic [31:0] v1,
                                       input logic r2, input logic [TAG_W-1:0] t2,
                                       input logic [31:0] v2, input logic issue_ready);
    stim_t s;
    s        = idleStim(issue_ready);
    s.dvalid = 1'b1;
    s.d.pc   = pc;
    s.d.inst = inst;
    s.d.rd   = rd;
    s.d.r1   = r1;
    s.d.t1   = t1;
    s.d.v1   = v1;
    s.d.r2   = r2;
    s.d.t2   = t2;
    s.d.v2   = v2;
    return s;
  endfunction

  function automatic stim_t randStim();
    stim_t s;
    s             = idleStim($urandom_range(0, 3) != 0);
    s.reset       = ($urandom_range(0, 127) == 0);
    s.flush       = ($urandom_range(0, 39) == 0);
    s.dvalid      = ($urandom_range(0, 9) < 6);
    s.d.pc        = $urandom;
    s.d.inst      = $urandom;
    s.d.rd        = TAG_W'($urandom_range(0, 63));
    s.d.r1        = $urandom_range(0, 1) == 1;
    s.d.t1        = TAG_W'($urandom_range(0, 7));
    s.d.v1        = $urandom;
    s.d.r2        = $urandom_range(0, 1) == 1;
    s.d.t2        = TAG_W'($urandom_range(0, 7));
    s.d.v2        = $urandom;
    s.cdb_valid   = $urandom_range(0, 1) == 1;
    s.cdb_tag     = TAG_W'($urandom_range(0, 7));
    s.cdb_value   = $urandom;
    return s;
  endfunction

  // Model step: predict this cycle's outputs from the pre-edge contents, then
  // advance the model with the spec rules (oldest ready issues, CDB wakes,
  // dispatch appends at the young end).
  task automatic stepModel(input stim_t s);
    int       cand;
    logic     exp_ready;
    logic     exp_issue;
    m_entry_t e;
    cand = -1;
    for (int i = 0; i < model_q.size(); i++) begin
      if (cand < 0 && model_q[i].r1 && model_q[i].r2) cand = i;
    end
    exp_ready = (model_q.size() < DEPTH) && !s.flush;
    exp_issue = (cand >= 0) && s.issue_ready && !s.flush && !s.reset;

    checkOutput("dispatch_ready", 64'(dispatch_ready_o), 64'(exp_ready));
    if (cand < 0) begin
      checkOutput("idle_pc",  64'(issue_pc_o),        64'h0);
      checkOutput("idle_rs1", 64'(issue_rs1_value_o), 64'h0);
      checkOutput("idle_rd",  64'(issue_rd_tag_o),    64'h0);
    end
    if (exp_issue) begin
      exp_q.push_back('{pc: model_q[cand].pc, inst: model_q[cand].inst,
                        v1: model_q[cand].v1, v2: model_q[cand].v2, rd: model_q[cand].rd});
    end

    if (s.reset || s.flush) begin
      model_q.delete();
    end else begin
      if (exp_issue) model_q.delete(cand);
      if (s.cdb_valid) begin
        foreach (model_q[i]) begin
          if (!model_q[i].r1 && model_q[i].t1 == s.cdb_tag) begin
            model_q[i].r1 = 1'b1;
            model_q[i].v1 = s.cdb_value;
          end
          if (!model_q[i].r2 && model_q[i].t2 == s.cdb_tag) begin
            model_q[i].r2 = 1'b1;
            model_q[i].v2 = s.cdb_value;
          end
        end
      end
      if (s.dvalid && exp_ready) begin
        e = s.d;
        if (s.cdb_valid && !e.r1 && e.t1 == s.cdb_tag) begin
          e.r1 = 1'b1;
          e.v1 = s.cdb_value;
        end
        if (s.cdb_valid && !e.r2 && e.t2 == s.cdb_tag) begin
          e.r2 = 1'b1;
          e.v2 = s.cdb_value;
        end
        model_q.push_back(e);
      end
    end
  endtask

  // Drive one cycle of inputs on the falling edge, then run the model for it.
  task automatic applyStimulus(input stim_t s);
    @(negedge clk_i);
    reset_i              = s.reset;
    flush_i              = s.flush;
    dispatch_valid_i     = s.dvalid;
    dispatch_pc_i        = s.d.pc;
    dispatch_inst_i      = s.d.inst;
    dispatch_rd_tag_i    = s.d.rd;
    dispatch_rs1_ready_i = s.d.r1;
    dispatch_rs1_tag_i   = s.d.t1;
    dispatch_rs1_value_i = s.d.v1;
    dispatch_rs2_ready_i = s.d.r2;
    dispatch_rs2_tag_i   = s.d.t2;
    dispatch_rs2_value_i = s.d.v2;
    cdb_valid_i          = s.cdb_valid;
    cdb_tag_i            = s.cdb_tag;
    cdb_value_i          = s.cdb_value;
    issue_ready_i        = s.issue_ready;
    #1;
    stepModel(s);
  endtask

  task automatic idleCycles(input int n, input logic issue_ready);
    for (int i = 0; i < n; i++) applyStimulus(idleStim(issue_ready));
  endtask

  // Monitor: whenever the DUT requests an issue, pop the oldest prediction and
  // compare; a prediction left unclaimed in a cycle is a missed issue.
  initial begin
    exp_issue_t e;
    forever begin
      @(negedge clk_i);
      #2;
      if (alu_request_o) begin
        if (exp_q.size() == 0) begin
          checkOutput("spurious_issue", 64'(alu_request_o), 64'h0);
        end else begin
          e = exp_q.pop_front();
          checkOutput("issue_pc",   64'(issue_pc_o),        64'(e.pc));
          checkOutput("issue_inst", 64'(issue_inst_o),      64'(e.inst));
          checkOutput("issue_rs1",  64'(issue_rs1_value_o), 64'(e.v1));
          checkOutput("issue_rs2",  64'(issue_rs2_value_o), 64'(e.v2));
          checkOutput("issue_rd",   64'(issue_rd_tag_o),    64'(e.rd));
        end
      end else if (exp_q.size() != 0) begin
        checkOutput("missed_issue", 64'(alu_request_o), 64'h1);
        exp_q.delete();
      end
    end
  end

  initial begin
    stim_t s;

    // Reset state
    s = idleStim(1'b1);
    s.reset = 1'b1;
    applyStimulus(s);
    applyStimulus(s);
    applyStimulus(idleStim(1'b1));
    checkOutput("reset_alu_request", 64'(alu_request_o), 64'h0);
    checkOutput("reset_dispatch_ready", 64'(dispatch_ready_o), 64'h1);

    // Single ADD issues the cycle after dispatch
    applyStimulus(mkDispatch(32'h100, 32'h002081B3, 6'd3, 1'b1, 6'd0, 32'd5,
                             1'b1, 6'd0, 32'd7, 1'b1));
    idleCycles(2, 1'b1);

    // A waits on tag 9, younger B is ready and overtakes it
    applyStimulus(mkDispatch(32'h200, 32'h00A00093, 6'd10, 1'b0, 6'd9, 32'h0,
                             1'b1, 6'd0, 32'd2, 1'b1));
    applyStimulus(mkDispatch(32'h204, 32'h00B00113, 6'd11, 1'b1, 6'd0, 32'd3,
                             1'b1, 6'd0, 32'd4, 1'b1));
    idleCycles(1, 1'b1);
    s = idleStim(1'b1);
    s.cdb_valid = 1'b1;
    s.cdb_tag   = 6'd9;
    s.cdb_value = 32'h55;
    applyStimulus(s);
    idleCycles(2, 1'b1);

    // Same-cycle CDB bypass into a dispatching source
    s = mkDispatch(32'h300, 32'h003100B3, 6'd13, 1'b1, 6'd0, 32'd1,
                   1'b0, 6'd12, 32'h0, 1'b1);
    s.cdb_valid = 1'b1;
    s.cdb_tag   = 6'd12;
    s.cdb_value = 32'hABCD;
    applyStimulus(s);
    idleCycles(2, 1'b1);

    // Fill with four waiting entries, refuse a fifth, wake the middle one
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(mkDispatch(32'h400 + 32'(4 * i), 32'h1000 + 32'(i), 6'(40 + i),
                               1'b1, 6'd0, 32'(i), 1'b0, 6'(20 + i), 32'h0, 1'b0));
    end
    applyStimulus(mkDispatch(32'h4F0, 32'h1FFF, 6'd50, 1'b1, 6'd0, 32'd9,
                             1'b1, 6'd0, 32'd9, 1'b1));
    s = idleStim(1'b1);
    s.cdb_valid = 1'b1;
    s.cdb_tag   = 6'd22;
    s.cdb_value = 32'h2222;
    applyStimulus(s);
    applyStimulus(mkDispatch(32'h4F4, 32'h1EEE, 6'd51, 1'b1, 6'd0, 32'd8,
                             1'b1, 6'd0, 32'd8, 1'b1));
    applyStimulus(mkDispatch(32'h4F8, 32'h1DDD, 6'd52, 1'b1, 6'd0, 32'd7,
                             1'b1, 6'd0, 32'd7, 1'b1));
    idleCycles(2, 1'b1);
    s = idleStim(1'b1);
    s.flush = 1'b1;
    applyStimulus(s);

    // Back-pressure holds two ready entries, then they drain in age order
    applyStimulus(mkDispatch(32'h500, 32'h2000, 6'd30, 1'b1, 6'd0, 32'hA1,
                             1'b1, 6'd0, 32'hB1, 1'b0));
    applyStimulus(mkDispatch(32'h504, 32'h2001, 6'd31, 1'b1, 6'd0, 32'hA2,
                             1'b1, 6'd0, 32'hB2, 1'b0));
    idleCycles(3, 1'b0);
    idleCycles(3, 1'b1);

    // Flush, then reset, each with a concurrent dispatch and three loaded entries
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 3; i++) begin
        applyStimulus(mkDispatch(32'h600 + 32'(4 * i), 32'h3000 + 32'(i), 6'(i),
                                 1'b0, 6'(30 + i), 32'h0, 1'b1, 6'd0, 32'd1, 1'b1));
      end
      s = mkDispatch(32'h6F0, 32'h3FFF, 6'd60, 1'b1, 6'd0, 32'd1,
                     1'b1, 6'd0, 32'd2, 1'b1);
      if (pass == 0) s.flush = 1'b1;
      else           s.reset = 1'b1;
      applyStimulus(s);
      idleCycles(2, 1'b1);
    end

    // Random traffic
    for (int n = 0; n < 3000; n++) applyStimulus(randStim());

    // Drain
    s = idleStim(1'b1);
    s.flush = 1'b1;
    applyStimulus(s);
    idleCycles(2, 1'b1);
    #5;
    checkOutput("final_pending_predictions", 64'(exp_q.size()), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
    $finish;
  end

endmodule

// File: doc/alu_issue_queue.md
Name: alu_issue_queue

Overview:
- Reservation station that feeds the single-cycle arithmetic unit; it is the requesting side of the `alu_request`/`pc`/`inst`/`rs1_value`/`rs2_value` interface.
- Accepts dispatched ALU-class instructions (OP, OP_IMM, LUI, AUIPC, JAL, JALR) whose source operands may still be pending.
- Snoops the common data bus (CDB) to wake pending operands.
- Issues the oldest instruction whose operands are both ready, one per cycle, along with its destination tag for CDB broadcast.

Parameters:
- DEPTH, 4, number of entries (power of two, ≥2).
- TAG_W, 6, width of physical/ROB tags.

Ports:
- clk_i  input  1  clock, all state on rising edge.
- reset_i  input  1  synchronous, active-high reset.
- flush_i  input  1  discard all entries (mispredict recovery).
- dispatch_valid_i  input  1  dispatch request.
- dispatch_ready_o  output  1  queue can accept a dispatch this cycle.
- dispatch_pc_i  input  32  instruction PC.
- dispatch_inst_i  input  32  raw instruction word.
- dispatch_rd_tag_i  input  TAG_W  destination tag.
- dispatch_rs1_ready_i  input  1  rs1 value valid at dispatch.
- dispatch_rs1_tag_i  input  TAG_W  producer tag when rs1 not ready.
- dispatch_rs1_value_i  input  32  rs1 value when ready.
- dispatch_rs2_ready_i, dispatch_rs2_tag_i, dispatch_rs2_value_i: same as rs1, for rs2.
- cdb_valid_i  input  1  CDB broadcast valid.
- cdb_tag_i  input  TAG_W  broadcast tag.
- cdb_value_i  input  32  broadcast value.
- issue_ready_i  input  1  downstream (ALU/CDB slot) accepts an issue.
- alu_request_o  output  1  issue valid to arithmetic unit.
- issue_pc_o  output  32  PC of issued entry.
- issue_inst_o  output  32  instruction of issued entry.
- issue_rs1_value_o  output  32  resolved rs1 value.
- issue_rs2_value_o  output  32  resolved rs2 value.
- issue_rd_tag_o  output  TAG_W  destination tag of issued entry.

Behaviour:
- Storage and ordering
  - Compacting queue: entry 0 is the oldest; `count` runs 0..DEPTH.
  - Each entry holds valid, pc, inst, rd_tag, and per source {ready, tag, value}.
- Reset
  - All entries invalid, count=0.
  - Outputs: `dispatch_ready_o`=1, `alu_request_o`=0, all issue data outputs 0.
- Dispatch
  - `dispatch_ready_o` = (count<DEPTH) and not `flush_i`; it does not depend on same-cycle issue.
  - A dispatch is accepted when `dispatch_valid_i` & `dispatch_ready_o`.
  - The accepted entry is written at the edge into the first free slot after compaction.
- Select
  - Combinational from registered state only. There is no combinational path from any dispatch or CDB input to the issue outputs.
  - Selects the lowest-index valid entry with rs1.ready & rs2.ready.
  - `alu_request_o` = a candidate exists & `issue_ready_i` & not `flush_i`.
  - Issue data outputs reflect the selected entry and are zero when no candidate exists.
- Issue removal
  - When `alu_request_o`=1, the selected entry is removed at the edge.
  - Younger entries shift down one slot; relative age is preserved.
- Wakeup
  - While `cdb_valid_i`, every valid entry with a non-ready source whose tag equals `cdb_tag_i` sets ready and captures `cdb_value_i` at the edge.
  - Such an entry is issuable no earlier than the next cycle.
  - Wakeup applies to entries shifted in the same cycle; the shift and the wakeup compose.
- Dispatch bypass
  - An incoming source with ready=0 whose tag matches a same-cycle CDB broadcast is stored ready with `cdb_value_i`.
  - A source with ready=1 ignores the CDB.
- Latency
  - Dispatch accepted in cycle N with both sources ready → earliest `alu_request_o` in cycle N+1.
  - CDB wakeup in cycle N → earliest issue in N+1.
- Simultaneous issue and dispatch
  - Allowed at any count < DEPTH.
  - The new entry lands at index (count-1) after the shift, so count is unchanged.
- Full
  - count=DEPTH → `dispatch_ready_o`=0, even if an issue occurs that cycle.
  - One bubble on dispatch after full is accepted.
- Flush
  - All entries are invalidated at the edge and count=0.
  - `alu_request_o` is forced 0 in the flush cycle; no dispatch is accepted.
- Reset priority
  - Reset dominates flush, dispatch and wakeup.
  - Reset mid-operation drops all entries with no issue that cycle.
- Instructions without register sources
  - Instructions with unused sources (LUI, AUIPC, JAL) are dispatched with ready=1 and value 0.
  - The queue does not decode opcodes.

Test Plan:
- Reset, then dispatch ADD (inst=0x002081B3, pc=0x100, both ready, rs1=5, rs2=7, rd_tag=3) with `issue_ready_i`=1 → next cycle `alu_request_o`=1, pc=0x100, rs1=5, rs2=7, rd_tag=3; queue empty afterwards.
- Dispatch A (rs1 waiting on tag 9), then B (ready) → B issues first; CDB tag 9 value 0x55 → A issues the following cycle with rs1=0x55.
- Dispatch with rs2 tag 12 not ready while `cdb_valid_i`, tag 12, value 0xABCD in the same cycle → entry stored ready; issues next cycle with rs2=0xABCD.
- Fill 4 waiting entries → `dispatch_ready_o`=0; wake entry 2 → it issues, count=3, `dispatch_ready_o`=1 the next cycle; older entries 0 and 1 retain order.
- Hold `issue_ready_i`=0 with 2 ready entries → `alu_request_o`=0 and no state change; release → entries issue in age order on consecutive cycles.
- Load 3 entries, assert `flush_i` with a concurrent dispatch → no issue, no accept; next cycle count=0, `dispatch_ready_o`=1. Repeat with `reset_i` mid-stream → same result.
